preif_pc_gen: RTL and testbench

- Pre-IF stage: owns the architectural fetch PC and produces the PC and exception bundle consumed by the IF-stage register (PREIF_PC / PREIF_ExceptType).
- Selects the next PC by priority: exception/ERET redirect, then branch redirect, then sequential PC+4.
- Holds a redirect that arrives while the pipeline is stalled, so no redirect is ever lost.
- Flags fetch-address misalignment as an IF-side address-error exception.

---
 rtl/preif_pc_gen_pkg.sv | 30 +++
 rtl/preif_redirect_buf.sv | 61 ++++++
 rtl/preif_pc_gen.sv | 88 ++++++++
 tb/tb_preif_pc_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/preif_pc_gen_pkg.sv
// Shared types and constants for the pre-IF PC generator.
package preif_pc_gen_pkg;

  // Default PC loaded on reset (MIPS boot ROM vector).
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  // Default sequential fetch increment in bytes.
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

  // Per-instruction exception bundle that travels down the pipeline.
  typedef struct packed {
    logic Interrupt;
    logic AddrErrIF;
    logic ReservedInst;
    logic Syscall;
    logic Break;
    logic Eret;
    logic Overflow;
    logic AddrErrSt;
    logic AddrErrLd;
  } ExceptinPipeType;

  // Redirect-pending state held while the fetch stage is stalled.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND_BR  = 2'd1,
    PEND_EXC = 2'd2
  } pc_pend_e;

endpackage

// File: rtl/preif_redirect_buf.sv
// Captures a redirect that arrives while fetch is stalled so it can be
// applied on the first cycle the IF register accepts a new PC.
// Exception redirects outrank branch redirects; a younger branch replaces
// an older pending branch, but never a pending exception.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module preif_redirect_buf
  import preif_pc_gen_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic        i_exc_redirect,
  input  logic [31:0] i_exc_target,
  input  logic        i_br_redirect,
  input  logic [31:0] i_br_target,
  output logic        o_pend_valid,
  output logic        o_pend_is_exc,
  output logic [31:0] o_pend_target,
  output pc_pend_e    o_dbg_state
);

  pc_pend_e    r_state;
  pc_pend_e    w_next_state;
  logic [31:0] r_target;
  logic [31:0] w_next_target;

  // State and pending-target registers.
  always_ff @(posedge i_clk) begin
    if (i_rst == `RstEnable) begin
      r_state  <= IDLE;
      r_target <= 32'h0000_0000;
    end else begin
      r_state  <= w_next_state;
      r_target <= w_next_target;
    end
  end

  // Next-state: an advance consumes any pending redirect; a stall records one.
  always_comb begin
    w_next_state  = r_state;
    w_next_target = r_target;
    if (i_wr) begin
      w_next_state = IDLE;
    end else if (i_exc_redirect) begin
      w_next_state  = PEND_EXC;
      w_next_target = i_exc_target;
    end else if (i_br_redirect && (r_state != PEND_EXC)) begin
      w_next_state  = PEND_BR;
      w_next_target = i_br_target;
    end
  end

  assign o_pend_valid  = (r_state != IDLE);
  assign o_pend_is_exc = (r_state == PEND_EXC);
  assign o_pend_target = r_target;
  assign o_dbg_state   = r_state;

endmodule

// File: rtl/preif_pc_gen.sv
// Pre-IF stage: owns the fetch PC, chooses the next PC by redirect priority
// and flags misaligned fetch addresses.
//
// Flow control: PREIF_Wr is the IF register write enable. When it is 1 the
// IF stage captures PREIF_PC this cycle and the PC advances; when 0 the PC
// holds and any redirect seen is buffered until the next cycle with
// PREIF_Wr=1. Redirect inputs are single-cycle pulses with no back-pressure.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module preif_pc_gen
  import preif_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PREIF_Wr,
  input  logic            EXC_Redirect,
  input  logic [31:0]     EXC_Target,
  input  logic            BR_Redirect,
  input  logic [31:0]     BR_Target,
  output logic [31:0]     PREIF_PC,
  output ExceptinPipeType PREIF_ExceptType,
  output logic            PREIF_RedirectFlush,
  output pc_pend_e        PREIF_DbgState
);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic        w_pend_valid;
  logic        w_pend_is_exc;
  logic [31:0] w_pend_target;

  preif_redirect_buf u_redirect_buf (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wr           (PREIF_Wr),
    .i_exc_redirect (EXC_Redirect),
    .i_exc_target   (EXC_Target),
    .i_br_redirect  (BR_Redirect),
    .i_br_target    (BR_Target),
    .o_pend_valid   (w_pend_valid),
    .o_pend_is_exc  (w_pend_is_exc),
    .o_pend_target  (w_pend_target),
    .o_dbg_state    (PREIF_DbgState)
  );

  // Next-PC mux: exceptions (live, then pending) beat branches (live, then
  // pending), which beat sequential fetch. Sequential add wraps mod 2^32.
  always_comb begin
    w_next_pc = r_pc;
    if (PREIF_Wr) begin
      if (EXC_Redirect) begin
        w_next_pc = EXC_Target;
      end else if (w_pend_is_exc) begin
        w_next_pc = w_pend_target;
      end else if (BR_Redirect) begin
        w_next_pc = BR_Target;
      end else if (w_pend_valid) begin
        w_next_pc = w_pend_target;
      end else begin
        w_next_pc = r_pc + PC_STEP;
      end
    end
  end

  // Architectural fetch PC register.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Only the IF-side address error originates here; all other causes are 0.
  always_comb begin
    PREIF_ExceptType           = '0;
    PREIF_ExceptType.AddrErrIF = (r_pc[1:0] != 2'b00);
  end

  assign PREIF_PC            = r_pc;
  assign PREIF_RedirectFlush = (EXC_Redirect | BR_Redirect | w_pend_valid) & PREIF_Wr;

endmodule

// File: tb/tb_preif_pc_gen.sv
// Directed bench for preif_pc_gen with hand-computed expected values.
module tb_preif_pc_gen;
  import preif_pc_gen_pkg::*;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            PREIF_Wr;
  logic            EXC_Redirect;
  logic [31:0]     EXC_Target;
  logic            BR_Redirect;
  logic [31:0]     BR_Target;
  logic [31:0]     PREIF_PC;
  ExceptinPipeType PREIF_ExceptType;
  logic            PREIF_RedirectFlush;
  pc_pend_e        PREIF_DbgState;

  always #5 clk = ~clk;

  preif_pc_gen dut (
    .clk                 (clk),
    .rst                 (rst),
    .PREIF_Wr            (PREIF_Wr),
    .EXC_Redirect        (EXC_Redirect),
    .EXC_Target          (EXC_Target),
    .BR_Redirect         (BR_Redirect),
    .BR_Target           (BR_Target),
    .PREIF_PC            (PREIF_PC),
    .PREIF_ExceptType    (PREIF_ExceptType),
    .PREIF_RedirectFlush (PREIF_RedirectFlush),
    .PREIF_DbgState      (PREIF_DbgState)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Full exception bundle with only AddrErrIF possibly set.
  function automatic logic [31:0] exp_exc(input logic addr_err);
    ExceptinPipeType e;
    e = '0;
    e.AddrErrIF = addr_err;
    return 32'(e);
  endfunction

  task automatic check_pc(input string tag, input logic [31:0] exp_pc, input logic addr_err);
    check({tag, ".pc"}, PREIF_PC, exp_pc);
    check({tag, ".exc"}, 32'(PREIF_ExceptType), exp_exc(addr_err));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are applied just after a rising edge; outputs are sampled 1ns
  // later, well away from the next active edge.
  task automatic drive(input logic wr, input logic exc, input logic [31:0] exc_t,
                       input logic br, input logic [31:0] br_t);
    PREIF_Wr     = wr;
    EXC_Redirect = exc;
    EXC_Target   = exc_t;
    BR_Redirect  = br;
    BR_Target    = br_t;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    check_pc("rst", 32'hBFC0_0000, 1'b0);
    check("rst.flush", 32'(PREIF_RedirectFlush), 32'd0);
    check("rst.state", 32'(PREIF_DbgState), 32'(IDLE));

    // 1. sequential fetch after reset
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("seq.flush", 32'(PREIF_RedirectFlush), 32'd0);
    tick(); check_pc("seq1", 32'hBFC0_0004, 1'b0);
    tick(); check_pc("seq2", 32'hBFC0_0008, 1'b0);
    tick(); check_pc("seq3", 32'hBFC0_000C, 1'b0);
    tick(); check_pc("seq4", 32'hBFC0_0010, 1'b0);

    // 2. branch while stalled, released after 3 stall cycles
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_1000);
    check("br_stall.flush", 32'(PREIF_RedirectFlush), 32'd0);
    tick(); check_pc("br_stall1", 32'hBFC0_0010, 1'b0);
    check("br_stall.state", 32'(PREIF_DbgState), 32'(PEND_BR));
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("br_stall2", 32'hBFC0_0010, 1'b0);
    tick(); check_pc("br_stall3", 32'hBFC0_0010, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("br_rel.flush", 32'(PREIF_RedirectFlush), 32'd1);
    tick(); check_pc("br_rel", 32'h8000_1000, 1'b0);
    check("br_rel.flush_after", 32'(PREIF_RedirectFlush), 32'd0);
    check("br_rel.state", 32'(PREIF_DbgState), 32'(IDLE));
    tick(); check_pc("br_rel_seq", 32'h8000_1004, 1'b0);

    // 3a. pending branch overwritten by exception
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_2000);
    tick();
    drive(1'b0, 1'b1, 32'hBFC0_0380, 1'b0, 32'h0);
    tick(); check("exc_over.state", 32'(PREIF_DbgState), 32'(PEND_EXC));
    check_pc("exc_over_hold", 32'h8000_1004, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("exc_over", 32'hBFC0_0380, 1'b0);

    // 3b. pending exception ignores a later branch
    drive(1'b0, 1'b1, 32'hBFC0_0400, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_4000);
    tick(); check("exc_keep.state", 32'(PREIF_DbgState), 32'(PEND_EXC));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("exc_keep", 32'hBFC0_0400, 1'b0);

    // 3c. younger pending branch wins; live branch on release beats neither pending exc
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_5000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_6000);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("br_young", 32'h8000_6000, 1'b0);

    // 4. simultaneous EXC and BR while advancing
    drive(1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 32'h8000_3000);
    check("simul.flush", 32'(PREIF_RedirectFlush), 32'd1);
    tick(); check_pc("simul", 32'hBFC0_0380, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("simul_seq", 32'hBFC0_0384, 1'b0);

    // 4b. simultaneous EXC and BR while stalled
    drive(1'b0, 1'b1, 32'hBFC0_0500, 1'b1, 32'h8000_7000);
    tick(); check("simul_stall.state", 32'(PREIF_DbgState), 32'(PEND_EXC));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("simul_stall", 32'hBFC0_0500, 1'b0);

    // 5. misaligned target: flagged, keeps stepping, cleared by redirect
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0002);
    tick(); check_pc("misal1", 32'h8000_0002, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("misal2", 32'h8000_0006, 1'b1);
    drive(1'b1, 1'b1, 32'hBFC0_0380, 1'b0, 32'h0);
    tick(); check_pc("misal_clr", 32'hBFC0_0380, 1'b0);

    // 5b. sequential wrap at the top of the address space
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick(); check_pc("wrap_pre", 32'hFFFF_FFFC, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); check_pc("wrap", 32'h0000_0000, 1'b0);

    // 6. reset clears a pending branch
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_8000);
    tick(); check("rst_pend.state", 32'(PREIF_DbgState), 32'(PEND_BR));
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h8765_4320);
    tick(); check_pc("rst_pend", 32'hBFC0_0000, 1'b0);
    check("rst_pend.state_idle", 32'(PREIF_DbgState), 32'(IDLE));
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_pend.flush", 32'(PREIF_RedirectFlush), 32'd0);
    tick(); check_pc("rst_pend_seq", 32'hBFC0_0004, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
